if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a request/ready instruction-memory port.
- Absorbs memory wait states, holds a fetched word while the hazard unit stalls, and applies branch/jump redirects from ID.
- Presents oInstr/oNextPC for IF/ID to latch when its enable (= !iStall) is high; presents NOP (32'b0) when no valid instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high reset.
- iStall  input  1  hazard unit: IF/ID will not accept this cycle.
- iRedirect  input  1  ID-resolved taken branch or jump.
- iRedirectPC  input  32  redirect target; bits [1:0] ignored (forced 00).
- imem_req  output  1  instruction-memory request.
- imem_addr  output  32  word-aligned fetch address.
- imem_ready  input  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  input  32  fetched instruction word.
- oInstr  output  32  instruction to IF/ID; 32'b0 when oValid=0.
- oNextPC  output  32  fetch address + 4 to IF/ID; 32'b0 when oValid=0.
- oValid  output  1  oInstr/oNextPC carry a real instruction.

Behaviour:
- Clock and reset: single clock domain, posedge clk. Reset is synchronous and active-high.
- While reset=1:
  - PC <= RESET_PC; state <= FETCH; hold buffer <= 0.
  - imem_req=0, oValid=0, oInstr=0, oNextPC=0 (outputs gated combinationally by reset).
  - First request: cycle after deassert, imem_addr=RESET_PC.
- Accept rule: an instruction is consumed when oValid=1 and iStall=0.
- Priority: iRedirect > imem_ready > iStall. When iRedirect=1, oValid is forced 0 that cycle.
- State FETCH:
  - imem_req=1, imem_addr=PC.
  - ready=1, !stall: oValid=1, oInstr=imem_rdata, oNextPC=PC+4; PC<=PC+4; stay in FETCH. Zero-wait memory sustains 1 instruction/cycle.
  - ready=1, stall: oValid=1 (same values); buffer<=imem_rdata; go to HOLD; PC unchanged.
  - ready=0: oValid=0; address held stable.
  - redirect with ready=1: response discarded; PC<=target; stay in FETCH.
  - redirect with ready=0: pending<=target; go to DRAIN.
- State HOLD:
  - imem_req=0; oValid=1, oInstr=buffer, oNextPC=PC+4.
  - !stall: PC<=PC+4; go to FETCH.
  - redirect: buffer discarded; PC<=target; go to FETCH.
- State DRAIN:
  - imem_req=1; imem_addr held at the outstanding (old) address; oValid=0.
  - ready=1: response discarded; PC<=pending; go to FETCH.
  - A further redirect overwrites pending. If it coincides with ready, the new target wins.
- imem_addr never changes while a request is outstanding (req=1, ready=0).
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000. PC[1:0] is always 00.
- Reset mid-operation (DRAIN or HOLD): state is abandoned next edge. The memory response returning during or after reset is ignored until the reset fetch issues.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- Defined: adds outputs oFetchCount[31:0] (increments per accepted instruction) and oWaitCount[31:0] (increments per cycle with imem_req=1 and imem_ready=0).
  - Both counters cleared by reset and wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, RESET_PC=32'h40, reset high 2 cycles, ready=1, rdata=32'h20080005 -> cycle after deassert: imem_addr=32'h40, oValid=1, oInstr=32'h20080005, oNextPC=32'h44; next cycle addr=32'h44.
- ready=0 for 2 cycles at PC 32'h44 -> oValid=0, oInstr=0, addr held 32'h44 both cycles; third cycle ready=1 -> oValid=1, oNextPC=32'h48.
- ready=1 with rdata=32'hAC220000 at PC 32'h48, iStall high 3 cycles -> HOLD; imem_req=0; oInstr=32'hAC220000, oValid=1 all 3 cycles; after stall drops, addr=32'h4C.
- At PC 32'h50, ready=0, pulse iRedirect with iRedirectPC=32'h103 -> oValid=0; addr stays 32'h50 until ready; that response is discarded; next request addr=32'h100.
- In HOLD, iStall=1 and iRedirect=1 with target 32'h200 -> oValid=0 that cycle; next cycle addr=32'h200; held word never re-presented.
- PC=32'hFFFFFFFC, ready=1 -> oNextPC=32'h0; next imem_addr=32'h0.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/ready port between the fetch stage and imem.
// The fetch stage is the master; it holds imem_addr until imem_ready.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: PC owner, imem wait/stall/redirect handling.
// Define IF_FETCH_PERF_EN to add fetch and wait-cycle counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         iStall,
  input  logic         iRedirect,
  input  logic [31:0]  iRedirectPC,
  if_fetch_unit_if.master imem,
  output logic [31:0]  oInstr,
  output logic [31:0]  oNextPC,
`ifdef IF_FETCH_PERF_EN
  output logic [31:0]  oFetchCount,
  output logic [31:0]  oWaitCount,
`endif
  output logic         oValid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, stateNext;
  logic [31:0] pc, pcNext;
  logic [31:0] holdBuf, holdBufNext;
  logic [31:0] pending, pendingNext;
  logic [31:0] pcPlus4;
  logic [31:0] target;
  logic        req, valid;
  logic [31:0] instr, nextPC;

  assign pcPlus4 = pc + 32'd4;
  assign target  = {iRedirectPC[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      holdBuf <= 32'd0;
      pending <= 32'd0;
    end else begin
      state   <= stateNext;
      pc      <= pcNext;
      holdBuf <= holdBufNext;
      pending <= pendingNext;
    end
  end

  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    holdBufNext = holdBuf;
    pendingNext = pending;
    req         = 1'b0;
    valid       = 1'b0;
    instr       = 32'd0;
    nextPC      = 32'd0;
    unique case (state)
      FETCH: begin
        req = 1'b1;
        if (iRedirect) begin
          if (imem.imem_ready) begin
            pcNext = target;
          end else begin
            pendingNext = target;
            stateNext   = DRAIN;
          end
        end else if (imem.imem_ready) begin
          valid  = 1'b1;
          instr  = imem.imem_rdata;
          nextPC = pcPlus4;
          if (iStall) begin
            holdBufNext = imem.imem_rdata;
            stateNext   = HOLD;
          end else begin
            pcNext = pcPlus4;
          end
        end
      end
      HOLD: begin
        instr  = holdBuf;
        nextPC = pcPlus4;
        if (iRedirect) begin
          pcNext    = target;
          stateNext = FETCH;
        end else begin
          valid = 1'b1;
          if (!iStall) begin
            pcNext    = pcPlus4;
            stateNext = FETCH;
          end
        end
      end
      DRAIN: begin
        // Old request still outstanding: keep its address, drop its data.
        req = 1'b1;
        if (iRedirect) pendingNext = target;
        if (imem.imem_ready) begin
          pcNext    = iRedirect ? target : pending;
          stateNext = FETCH;
        end
      end
      default: stateNext = FETCH;
    endcase
  end

  assign imem.imem_req  = req & ~reset;
  assign imem.imem_addr = pc;
  assign oValid  = valid & ~reset;
  assign oInstr  = oValid ? instr  : 32'd0;
  assign oNextPC = oValid ? nextPC : 32'd0;

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      oFetchCount <= 32'd0;
      oWaitCount  <= 32'd0;
    end else begin
      if (oValid && !iStall)
        oFetchCount <= oFetchCount + 32'd1;
      if (imem.imem_req && !imem.imem_ready)
        oWaitCount <= oWaitCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_if_fetch_unit;
  localparam logic [31:0] RPC = 32'h40;

  logic        clk = 1'b0;
  logic        reset;
  logic        iStall, iRedirect;
  logic [31:0] iRedirectPC;
  logic [31:0] oInstr, oNextPC;
  logic        oValid;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] oFetchCount, oWaitCount;
  logic [31:0] mFetch, mWait;
`endif

  if_fetch_unit_if imem ();

  if_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .reset(reset),
    .iStall(iStall),
    .iRedirect(iRedirect),
    .iRedirectPC(iRedirectPC),
    .imem(imem.master),
    .oInstr(oInstr),
    .oNextPC(oNextPC),
`ifdef IF_FETCH_PERF_EN
    .oFetchCount(oFetchCount),
    .oWaitCount(oWaitCount),
`endif
    .oValid(oValid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: where fetching stands, a stalled word waiting to be taken,
  // and whether the outstanding response must be thrown away.
  logic [31:0] mPC;
  logic        mHeld;
  logic [31:0] mWord;
  logic        mDiscard;
  logic [31:0] mDest;
  logic        prevOut;
  logic [31:0] prevAddr;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic rd,
                      input logic [31:0] rpc, input logic rdy,
                      input logic [31:0] data);
    logic        eReq, eVal;
    logic [31:0] eIns, eNpc, tgt;
    @(negedge clk);
    reset = rst; iStall = st; iRedirect = rd; iRedirectPC = rpc;
    imem.imem_ready = rdy; imem.imem_rdata = data;
    #1;
    tgt = rpc & 32'hFFFF_FFFC;
    eReq = 1'b0; eVal = 1'b0; eIns = 32'd0; eNpc = 32'd0;
    if (!rst) begin
      if (mHeld) begin
        eVal = !rd; eIns = mWord; eNpc = mPC + 32'd4;
      end else begin
        eReq = 1'b1;
        if (!mDiscard && !rd && rdy) begin
          eVal = 1'b1; eIns = data; eNpc = mPC + 32'd4;
        end
      end
      if (!eVal) begin eIns = 32'd0; eNpc = 32'd0; end
    end
    chk("req", {31'd0, imem.imem_req}, {31'd0, eReq});
    chk("valid", {31'd0, oValid}, {31'd0, eVal});
    chk("instr", oInstr, eIns);
    chk("nextpc", oNextPC, eNpc);
    if (eReq) chk("addr", imem.imem_addr, mPC);
    if (!rst && prevOut) chk("addr_stable", imem.imem_addr, prevAddr);
`ifdef IF_FETCH_PERF_EN
    chk("fetchcnt", oFetchCount, mFetch);
    chk("waitcnt", oWaitCount, mWait);
    if (rst) begin
      mFetch = 0; mWait = 0;
    end else begin
      if (eVal && !st) mFetch = mFetch + 1;
      if (eReq && !rdy) mWait = mWait + 1;
    end
`endif
    prevOut  = eReq && !rdy;
    prevAddr = mPC;
    if (rst) begin
      mPC = RPC; mHeld = 0; mDiscard = 0;
    end else if (mHeld) begin
      if (rd) begin mPC = tgt; mHeld = 0; end
      else if (!st) begin mPC = mPC + 32'd4; mHeld = 0; end
    end else begin
      if (rd) begin mDest = tgt; end
      if (rd && !rdy) mDiscard = 1;
      if (rdy) begin
        if (rd || mDiscard) mPC = mDest;
        else if (st) begin mHeld = 1; mWord = data; end
        else mPC = mPC + 32'd4;
        mDiscard = 0;
      end
    end
  endtask

  initial begin
    reset = 1; iStall = 0; iRedirect = 0; iRedirectPC = 0;
    imem.imem_ready = 0; imem.imem_rdata = 0;
    mPC = RPC; mHeld = 0; mWord = 0; mDiscard = 0; mDest = 0;
    prevOut = 0; prevAddr = 0;
`ifdef IF_FETCH_PERF_EN
    mFetch = 0; mWait = 0;
`endif
    step(1, 0, 0, 0, 1, 32'h20080005);
    step(1, 0, 0, 0, 1, 32'h20080005);
    chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
    chk("rst_valid", {31'd0, oValid}, 32'd0);
    step(0, 0, 0, 0, 1, 32'h20080005);
    chk("t1_addr", imem.imem_addr, 32'h40);
    chk("t1_instr", oInstr, 32'h20080005);
    chk("t1_npc", oNextPC, 32'h44);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("t2_addr_a", imem.imem_addr, 32'h44);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("t2_addr_b", imem.imem_addr, 32'h44);
    chk("t2_instr", oInstr, 32'h0);
    step(0, 0, 0, 0, 1, 32'h1234);
    chk("t2_npc", oNextPC, 32'h48);
    step(0, 1, 0, 0, 1, 32'hAC220000);
    chk("t3_instr_a", oInstr, 32'hAC220000);
    step(0, 1, 0, 0, 1, 32'h0);
    chk("t3_req", {31'd0, imem.imem_req}, 32'd0);
    step(0, 1, 0, 0, 1, 32'h0);
    chk("t3_instr_b", oInstr, 32'hAC220000);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("t3_valid", {31'd0, oValid}, 32'd1);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("t3_addr", imem.imem_addr, 32'h4C);
    step(0, 0, 0, 0, 1, 32'h5);
    step(0, 0, 1, 32'h103, 0, 32'h0);
    chk("t4_valid", {31'd0, oValid}, 32'd0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("t4_addr_a", imem.imem_addr, 32'h50);
    step(0, 0, 0, 0, 1, 32'hDEAD);
    chk("t4_discard", {31'd0, oValid}, 32'd0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("t4_addr_b", imem.imem_addr, 32'h100);
    step(0, 1, 0, 0, 1, 32'h77);
    step(0, 1, 1, 32'h200, 1, 32'h0);
    chk("t5_valid", {31'd0, oValid}, 32'd0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("t5_addr", imem.imem_addr, 32'h200);
    step(0, 0, 1, 32'hFFFF_FFFF, 1, 32'h0);
    step(0, 0, 0, 0, 1, 32'h99);
    chk("t6_addr", imem.imem_addr, 32'hFFFF_FFFC);
    chk("t6_npc", oNextPC, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    chk("t6_wrap", imem.imem_addr, 32'h0);
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(99) < 2, $urandom_range(99) < 30,
           $urandom_range(99) < 10, $urandom,
           $urandom_range(99) < 65, $urandom);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
